sign_saturate: RTL

Streaming signed-narrowing stage: the inverse direction of sign extension. It reduces a two's-complement sample from `p_INPUT_WIDTH` to `p_OUTPUT_WIDTH` bits and clamps out-of-range values to the output's most positive or most negative code. It sits on valid/ready datapaths, for example after accumulators or multipliers, and feeds narrower consumers. A per-sample saturation flag and a saturating event counter are provided for overflow monitoring.

---
 rtl/sign_saturate_if.sv | 34 +++
 rtl/sign_saturate.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sign_saturate_if.sv
// Valid/ready sample stream seen by sign_saturate: wide samples in, narrowed samples out.
// The slave modport is the narrowing stage; the master modport drives it and consumes results.
interface sign_saturate_if #(
    parameter int unsigned p_INPUT_WIDTH  = 16,
    parameter int unsigned p_OUTPUT_WIDTH = 8
);
    logic                      i_VALID;
    logic                      o_READY;
    logic [p_INPUT_WIDTH-1:0]  i_INPUT;
    logic                      o_VALID;
    logic                      i_READY;
    logic [p_OUTPUT_WIDTH-1:0] o_OUTPUT;
    logic                      o_SAT;

    modport slave (
        input  i_VALID,
        input  i_INPUT,
        input  i_READY,
        output o_READY,
        output o_VALID,
        output o_OUTPUT,
        output o_SAT
    );

    modport master (
        output i_VALID,
        output i_INPUT,
        output i_READY,
        input  o_READY,
        input  o_VALID,
        input  o_OUTPUT,
        input  o_SAT
    );
endinterface

// File: rtl/sign_saturate.sv
// Streaming signed narrowing stage with clamping, a two-slot (output + skid) buffer,
// a per-sample saturation flag and a sticky saturation event counter.
module sign_saturate #(
    parameter int unsigned p_INPUT_WIDTH  = 16,
    parameter int unsigned p_OUTPUT_WIDTH = 8,
    parameter int unsigned p_COUNT_WIDTH  = 16
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    sign_saturate_if.slave           bus,
    input  logic                     i_CLEAR,
    output logic [p_COUNT_WIDTH-1:0] o_SAT_COUNT
);
    localparam int unsigned UpperWidth = p_INPUT_WIDTH - p_OUTPUT_WIDTH + 1;

    if (p_OUTPUT_WIDTH < 2 || p_INPUT_WIDTH <= p_OUTPUT_WIDTH || p_COUNT_WIDTH < 1) begin
        : g_param_check
        $error("sign_saturate: illegal width parameters");
    end

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [p_OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;
    logic [p_OUTPUT_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                      skid_sat_q, skid_sat_d;
    logic [p_COUNT_WIDTH-1:0]  count_q, count_d;

    logic                      ready_s;
    logic                      valid_s;
    logic                      in_acc;
    logic                      out_acc;
    logic [UpperWidth-1:0]     upper;
    logic                      fits;
    logic [p_OUTPUT_WIDTH-1:0] in_result;
    logic                      in_sat;

    // Handshake flags come straight from the state register: no input-to-ready/valid path.
    assign ready_s = (state_q != StFull);
    assign valid_s = (state_q != StEmpty);
    assign in_acc  = bus.i_VALID & ready_s;
    assign out_acc = valid_s & bus.i_READY;

    // The sample fits when every bit from the sign down to the output MSB agrees.
    assign upper = bus.i_INPUT[p_INPUT_WIDTH-1:p_OUTPUT_WIDTH-1];
    assign fits  = (&upper) | ~(|upper);

    always_comb begin
        in_result = bus.i_INPUT[p_OUTPUT_WIDTH-1:0];
        in_sat    = 1'b0;
        if (!fits) begin
            in_sat = 1'b1;
            if (bus.i_INPUT[p_INPUT_WIDTH-1]) begin
                in_result = {1'b1, {(p_OUTPUT_WIDTH-1){1'b0}}};
            end else begin
                in_result = {1'b0, {(p_OUTPUT_WIDTH-1){1'b1}}};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        skid_data_d = skid_data_q;
        skid_sat_d  = skid_sat_q;

        case (state_q)
            StEmpty: begin
                if (in_acc) begin
                    state_d    = StOne;
                    out_data_d = in_result;
                    out_sat_d  = in_sat;
                end
            end
            StOne: begin
                if (in_acc && out_acc) begin
                    out_data_d = in_result;
                    out_sat_d  = in_sat;
                end else if (in_acc) begin
                    state_d     = StFull;
                    skid_data_d = in_result;
                    skid_sat_d  = in_sat;
                end else if (out_acc) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_acc) begin
                    state_d    = StOne;
                    out_data_d = skid_data_q;
                    out_sat_d  = skid_sat_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Counting happens at input acceptance; a clear coinciding with a clamp leaves that clamp.
    always_comb begin
        count_d = count_q;
        if (i_CLEAR) begin
            count_d = (in_acc && in_sat) ? p_COUNT_WIDTH'(1) : '0;
        end else if (in_acc && in_sat && (count_q != '1)) begin
            count_d = count_q + p_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q     <= StEmpty;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            skid_data_q <= '0;
            skid_sat_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            skid_data_q <= skid_data_d;
            skid_sat_q  <= skid_sat_d;
            count_q     <= count_d;
        end
    end

    assign bus.o_READY  = ready_s;
    assign bus.o_VALID  = valid_s;
    assign bus.o_OUTPUT = out_data_q;
    assign bus.o_SAT    = out_sat_q;
    assign o_SAT_COUNT  = count_q;
endmodule
